// File: rtl/alu_ctrl_issue.sv
// alu_ctrl_issue: decodes ALUOp/funct7/funct3 to a registered ALU code and paces multiplies; ports clk_i rst_i flush_i valid_i ALUOp_i funct7_i funct3_i -> ALUCtrl_o valid_o stall_o illegal_o
module alu_ctrl_issue #(
  parameter int MUL_CYCLES = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       valid_i,
  input  logic [1:0] ALUOp_i,
  input  logic [6:0] funct7_i,
  input  logic [2:0] funct3_i,
  output logic [3:0] ALUCtrl_o,
  output logic       valid_o,
  output logic       stall_o,
  output logic       illegal_o
);
  localparam logic [3:0] C_ADD = 4'b0010, C_SUB = 4'b0110, C_AND = 4'b0000, C_OR = 4'b0001, C_MUL = 4'b1111;
  typedef enum logic {RUN, HOLD} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, ctrl_q, ctrl_d;
  logic valid_q, valid_d, stall_q, stall_d, illegal_q, illegal_d;
  logic f3_zero, logic_ok, f7_zero, f7_sub, f7_mul, is_mul, ill, accept;
  logic [3:0] lgc_code, code;
  always_comb begin
    f3_zero  = funct3_i == 3'b000;
    logic_ok = f3_zero | funct3_i == 3'b111 | funct3_i == 3'b110;
    f7_zero  = funct7_i == 7'b0000000;
    f7_sub   = funct7_i == 7'b0100000;
    f7_mul   = funct7_i == 7'b0000001;
    lgc_code = funct3_i == 3'b111 ? C_AND : funct3_i == 3'b110 ? C_OR : C_ADD;
    is_mul   = ALUOp_i == 2'b10 & f7_mul & f3_zero;
    code     = ALUOp_i == 2'b00 ? C_ADD :
               ALUOp_i == 2'b01 ? C_SUB :
               ALUOp_i == 2'b11 ? lgc_code :
               f7_sub & f3_zero ? C_SUB :
               is_mul           ? C_MUL :
               f7_zero          ? lgc_code : C_ADD;
    ill      = (ALUOp_i == 2'b11 & ~logic_ok) |
               (ALUOp_i == 2'b10 & ~((f7_zero & logic_ok) | ((f7_sub | f7_mul) & f3_zero)));
    accept   = valid_i & ~stall_q & ~flush_i;
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    valid_d   = 1'b0;
    stall_d   = 1'b0;
    illegal_d = 1'b0;
    if (flush_i) begin
      state_d = RUN;
      cnt_d   = 4'd0;
    end else if (state_q == HOLD) begin
      cnt_d   = cnt_q - 4'd1;
      stall_d = cnt_q > 4'd1;
      valid_d = cnt_q <= 4'd1;
      state_d = cnt_q > 4'd1 ? HOLD : RUN;
    end else if (accept) begin
      ctrl_d = code;
      if (is_mul && MUL_CYCLES > 1) begin
        state_d = HOLD;
        cnt_d   = 4'(MUL_CYCLES - 1);
        stall_d = 1'b1;
      end else begin
        valid_d   = 1'b1;
        illegal_d = ill;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      cnt_q     <= 4'd0;
      ctrl_q    <= C_ADD;
      valid_q   <= 1'b0;
      stall_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      stall_q   <= stall_d;
      illegal_q <= illegal_d;
    end
  end
  assign ALUCtrl_o = ctrl_q;
  assign valid_o   = valid_q;
  assign stall_o   = stall_q;
  assign illegal_o = illegal_q;
endmodule

// File: tb/tb_alu_ctrl_issue.sv
// tb_alu_ctrl_issue: random and directed checks of alu_ctrl_issue (MUL_CYCLES 3 and 1) against a behavioural model
module tb_alu_ctrl_issue;
  logic clk = 0, rst = 1, flush = 0, valid = 0;
  logic [1:0] op = 0;
  logic [6:0] f7 = 0;
  logic [2:0] f3 = 0;
  logic [3:0] ctrl3, ctrl1;
  logic vo3, so3, io3, vo1, so1, io1;
  int total = 0, bad = 0;
  logic [3:0] e_ctrl[2];
  logic e_v[2], e_s[2], e_i[2];
  int rem[2];
  always #5 clk = ~clk;
  alu_ctrl_issue #(.MUL_CYCLES(3)) u3 (.clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ALUOp_i(op),
    .funct7_i(f7), .funct3_i(f3), .ALUCtrl_o(ctrl3), .valid_o(vo3), .stall_o(so3), .illegal_o(io3));
  alu_ctrl_issue #(.MUL_CYCLES(1)) u1 (.clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ALUOp_i(op),
    .funct7_i(f7), .funct3_i(f3), .ALUCtrl_o(ctrl1), .valid_o(vo1), .stall_o(so1), .illegal_o(io1));
  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
    end
  endtask
  task automatic decode(output logic [3:0] c, output logic il, output logic mul);
    c = 4'b0010;
    il = 0;
    mul = 0;
    if (op == 2'b01) c = 4'b0110;
    else if (op == 2'b11)
      case (f3)
        3'b000: c = 4'b0010;
        3'b111: c = 4'b0000;
        3'b110: c = 4'b0001;
        default: il = 1;
      endcase
    else if (op == 2'b10)
      case ({f7, f3})
        10'b0000000_000: c = 4'b0010;
        10'b0000000_111: c = 4'b0000;
        10'b0000000_110: c = 4'b0001;
        10'b0100000_000: c = 4'b0110;
        10'b0000001_000: begin c = 4'b1111; mul = 1; end
        default: il = 1;
      endcase
  endtask
  task automatic model(input int i, input int m);
    logic [3:0] c;
    logic il, mul;
    if (rst) begin
      e_ctrl[i] = 4'b0010; e_v[i] = 0; e_s[i] = 0; e_i[i] = 0; rem[i] = 0;
    end else if (flush) begin
      e_v[i] = 0; e_s[i] = 0; e_i[i] = 0; rem[i] = 0;
    end else if (rem[i] > 0) begin
      rem[i]--;
      e_s[i] = rem[i] > 0;
      e_v[i] = rem[i] == 0;
      e_i[i] = 0;
    end else if (valid) begin
      decode(c, il, mul);
      e_ctrl[i] = c;
      e_i[i] = 0;
      if (mul && m > 1) begin
        rem[i] = m - 1; e_s[i] = 1; e_v[i] = 0;
      end else begin
        e_s[i] = 0; e_v[i] = 1; e_i[i] = il;
      end
    end else begin
      e_v[i] = 0; e_s[i] = 0; e_i[i] = 0;
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    model(0, 3);
    model(1, 1);
    @(negedge clk);
    check("m3_ctrl", ctrl3, e_ctrl[0]);
    check("m3_valid", 4'(vo3), 4'(e_v[0]));
    check("m3_stall", 4'(so3), 4'(e_s[0]));
    check("m3_illegal", 4'(io3), 4'(e_i[0]));
    check("m1_ctrl", ctrl1, e_ctrl[1]);
    check("m1_valid", 4'(vo1), 4'(e_v[1]));
    check("m1_stall", 4'(so1), 4'(e_s[1]));
    check("m1_illegal", 4'(io1), 4'(e_i[1]));
  endtask
  task automatic drive(input logic r, input logic fl, input logic v, input logic [1:0] o,
                       input logic [6:0] s7, input logic [2:0] s3, input int n);
    rst = r; flush = fl; valid = v; op = o; f7 = s7; f3 = s3;
    for (int k = 0; k < n; k++) cycle();
  endtask
  initial begin
    drive(1, 0, 1, 2'b10, 7'h01, 3'b000, 3);
    drive(0, 0, 0, 2'b10, 7'h01, 3'b000, 1);
    drive(0, 0, 1, 2'b10, 7'h00, 3'b000, 1);
    drive(0, 0, 1, 2'b10, 7'h20, 3'b000, 1);
    drive(0, 0, 1, 2'b10, 7'h00, 3'b111, 1);
    drive(0, 0, 1, 2'b10, 7'h00, 3'b110, 1);
    drive(0, 0, 1, 2'b10, 7'h01, 3'b000, 1);
    drive(0, 0, 1, 2'b10, 7'h20, 3'b000, 4);
    drive(0, 0, 1, 2'b11, 7'h55, 3'b001, 1);
    drive(0, 0, 1, 2'b00, 7'h7f, 3'b101, 1);
    drive(0, 0, 1, 2'b10, 7'h01, 3'b000, 1);
    drive(0, 0, 0, 2'b10, 7'h01, 3'b000, 1);
    drive(0, 1, 1, 2'b01, 7'h00, 3'b000, 1);
    drive(0, 0, 1, 2'b01, 7'h00, 3'b000, 1);
    drive(0, 0, 1, 2'b10, 7'h01, 3'b000, 2);
    drive(1, 0, 1, 2'b10, 7'h01, 3'b000, 1);
    drive(0, 0, 0, 2'b00, 7'h00, 3'b000, 2);
    for (int n = 0; n < 3000; n++) begin
      logic [6:0] r7;
      case ($urandom_range(3))
        0: r7 = 7'h00;
        1: r7 = 7'h20;
        2: r7 = 7'h01;
        default: r7 = 7'($urandom);
      endcase
      drive($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(3) != 0,
            2'($urandom), r7, 3'($urandom_range(1) == 0 ? 0 : $urandom), 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_issue.md
# alu_ctrl_issue

Issue-side control stage for the EX-stage ALU: it decodes ALUOp/funct7/funct3 into the 4-bit ALU operation code and registers it into EX. It also paces multi-cycle multiplies by holding the code stable and freezing the front end with a stall request. It sits between ID decode and the ALU, replacing ad-hoc combinational ALU control, and drives the ALU's control input directly.

## Interface
- MUL_CYCLES, 3, number of EX cycles a multiply occupies (legal 1..15)
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  synchronous pipeline flush; kills the held or incoming op
- valid_i  in  1  ID presents a valid instruction this cycle
- ALUOp_i  in  2  main-decoder class: 00 mem, 01 branch, 10 R-type, 11 I-type ALU
- funct7_i  in  7  instruction funct7
- funct3_i  in  3  instruction funct3
- ALUCtrl_o  out  4  ALU operation code to ALU, registered
- valid_o  out  1  ALU result is valid and consumed this cycle
- stall_o  out  1  front end must hold its current instruction
- illegal_o  out  1  one-cycle flag: accepted op had no legal encoding

## Operation
- Codes: ADD=0010, SUB=0110, AND=0000, OR=0001, MUL=1111.
- Decode table:
  - ALUOp 00 -> ADD; ALUOp 01 -> SUB; funct fields ignored.
  - ALUOp 10, funct7=0000000: funct3 000 ADD, 111 AND, 110 OR.
  - ALUOp 10, funct7=0100000, funct3 000 -> SUB.
  - ALUOp 10, funct7=0000001, funct3 000 -> MUL.
  - ALUOp 11 (funct7 ignored): funct3 000 ADD, 111 AND, 110 OR.
  - Anything else: ADD with illegal_o=1.
- Accept condition: valid_i & ~stall_o & ~flush_i, sampled at the rising edge.
- FSM states:
  - RUN: single-cycle ops go out normally.
  - HOLD: multiply in progress.
- Down-counter cnt, 4 bits.
- Accept of a non-MUL op, or MUL with MUL_CYCLES=1: next cycle ALUCtrl_o=code, valid_o=1, stall_o=0, stay RUN.
- Accept of MUL with MUL_CYCLES>1:
  - go HOLD with cnt=MUL_CYCLES-1.
  - ALUCtrl_o=1111.
  - stall_o=1, valid_o=0.
- In HOLD each edge decrements cnt; inputs are ignored.
- When cnt becomes 0: stall_o=0 and valid_o=1 for that one cycle, state returns to RUN. A new op may be accepted at the end of that cycle, so ops run back-to-back.
- No accept: valid_o=0, illegal_o=0, ALUCtrl_o holds its last value.
- illegal_o is asserted with valid_o for the illegal op only.
- flush_i: next cycle valid_o=0, stall_o=0, illegal_o=0, state RUN, cnt=0; ALUCtrl_o holds. Flush beats a same-cycle valid_i, and that instruction is dropped. A flush during HOLD aborts the multiply and produces no valid_o.
- rst_i beats flush_i and valid_i.

## Timing
- Reset values: ALUCtrl_o=0010, valid_o=0, stall_o=0, illegal_o=0, state RUN, cnt=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency: 1 cycle from accept to the first cycle of the op in EX.
- Occupancy: 1 cycle for non-MUL ops; MUL_CYCLES cycles for a multiply. stall_o is high for the first MUL_CYCLES-1 of them.
- ALUCtrl_o is stable for the whole multiply occupancy.
- Throughput: one accept per cycle when not stalled.
- Reset mid-HOLD: the next cycle shows the reset values; the in-flight multiply is lost.

## Test plan
- Reset, then hold rst_i 2 cycles with valid_i=1, ALUOp=10, funct7=0000001 -> outputs stay 0010/0/0/0 throughout and for the cycle after.
- Back-to-back ADD, SUB, AND, OR R-type ops, valid_i=1 every cycle -> ALUCtrl_o shows 0010, 0110, 0000, 0001 on consecutive cycles with valid_o=1 each, stall_o=0.
- MUL_CYCLES=3: MUL accepted at edge k -> ALUCtrl_o=1111 in cycles k+1..k+3; stall_o=1,1,0; valid_o=0,0,1. A following SUB held on the inputs appears in cycle k+4.
- ALUOp=11, funct3=001 -> ALUCtrl_o=0010, valid_o=1, illegal_o=1 for one cycle. ALUOp=00 with arbitrary funct -> 0010 with illegal_o=0.
- MUL accepted, flush_i=1 in cycle k+2 -> cycle k+3 shows stall_o=0, valid_o=0. An instruction presented with flush_i=1 is not accepted; it is accepted normally the next cycle.
- MUL_CYCLES=1: MUL -> single cycle with ALUCtrl_o=1111, valid_o=1, stall_o never asserted.
